// File: rtl/multicycle_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_pkg
//   Shared definitions for the multi-cycle RV32I control sequencer:
//   - state_e        : sequencer phases (3-bit binary encoding)
//   - OP_*           : the eight RV32I major opcodes the sequencer decodes
//   - PCSRC_*        : pc_source mux encodings
//   - SRCB_*         : alu_src_b mux encodings
//   - ALUOP_*        : alu_op encodings handed to the ALU control
//   - helper functions used by the next-state / output decode
// -----------------------------------------------------------------------------
package multicycle_pkg;

  // Sequencer phases. Encoding is fixed binary so that the state register
  // stays 3 bits wide and unused codes fall back to IF.
  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_ECALL = 3'd5,
    S_HALT  = 3'd6
  } state_e;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;  // ALU result this cycle
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;  // ALUOut register (PC+imm from ID)
  localparam logic [1:0] PCSRC_PC4    = 2'b10;  // PC+4 incrementer

  // ALU operand B mux
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // True for opcodes that need a MEM phase.
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // True for phases whose exit back to IF retires an instruction.
  function automatic logic is_retire_state(input state_e s);
    return (s == S_EX) || (s == S_MEM) || (s == S_WB) || (s == S_ECALL);
  endfunction

endpackage

// File: rtl/instret_counter.sv
// -----------------------------------------------------------------------------
// instret_counter
//   Retired-instruction counter. Increments by one on each enabled clock and
//   wraps modulo 2^CNT_W. Cleared asynchronously by reset_i.
//
//   Ports:
//     clk_i    : clock
//     reset_i  : asynchronous active-high reset, clears the count
//     en_i     : count enable (one retirement this cycle)
//     count_o  : current count
// -----------------------------------------------------------------------------
module instret_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Natural overflow of the adder gives the modulo-2^CNT_W wrap.
  assign count_d = en_i ? (count_q + CNT_W'(1)) : count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//   Control sequencer for the multi-cycle RV32I core. Steps the shared
//   datapath (PC, IR, MDR, A/B, ALUOut, one ALU, unified memory) through
//   IF -> ID -> EX -> [MEM] -> [WB], with an ECALL phase that can park the
//   core in HALT. Waits on the memory ready handshake in IF and MEM.
//
//   Ports:
//     clk        : clock
//     reset      : asynchronous active-high reset (state -> IF, instret -> 0,
//                  all control outputs forced low while asserted)
//     opcode     : IR[6:0], meaningful from ID onward
//     bcond      : ALU branch-compare result, meaningful in EX
//     mem_ready  : unified memory finishes the current access this cycle
//     halt_req   : x17 == 10, sampled in ECALL
//     pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
//     reg_write, mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op :
//                  datapath controls, decoded combinationally from the
//                  current phase, opcode, bcond and mem_ready
//     is_halted  : core is parked in HALT
//     instret    : retired-instruction count (CNT_W bits, wrapping)
// -----------------------------------------------------------------------------
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             pc_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_halted,
  output logic [CNT_W-1:0] instret
);

  state_e state_q;
  state_e state_d;

  // Raw decode, before the reset override.
  logic       pc_write_d;
  logic [1:0] pc_source_d;
  logic       i_or_d_d;
  logic       mem_read_d;
  logic       mem_write_d;
  logic       ir_write_d;
  logic       reg_write_d;
  logic       mem_to_reg_d;
  logic       pc_to_reg_d;
  logic       alu_src_a_d;
  logic [1:0] alu_src_b_d;
  logic [1:0] alu_op_d;
  logic       is_halted_d;

  logic       retire_en;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_write_d   = 1'b0;
    pc_source_d  = PCSRC_ALU;
    i_or_d_d     = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ir_write_d   = 1'b0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    pc_to_reg_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = SRCB_B;
    alu_op_d     = ALUOP_ADD;
    is_halted_d  = 1'b0;

    case (state_q)
      S_IF: begin
        // Instruction fetch from PC; read strobe held until memory is ready.
        mem_read_d = 1'b1;
        i_or_d_d   = 1'b0;
        if (mem_ready) begin
          ir_write_d = 1'b1;
          state_d    = S_ID;
        end
      end

      S_ID: begin
        // Speculatively form PC+imm into ALUOut for branch/jal targets.
        alu_src_a_d = 1'b0;
        alu_src_b_d = SRCB_IMM;
        alu_op_d    = ALUOP_ADD;
        state_d     = (opcode == OP_SYSTEM) ? S_ECALL : S_EX;
      end

      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = SRCB_B;
            alu_op_d    = ALUOP_FUNCT;
            state_d     = S_WB;
          end
          OP_I: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = SRCB_IMM;
            alu_op_d    = ALUOP_FUNCT;
            state_d     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            // Effective address A+imm goes to ALUOut for the MEM phase.
            alu_src_a_d = 1'b1;
            alu_src_b_d = SRCB_IMM;
            alu_op_d    = ALUOP_ADD;
            state_d     = S_MEM;
          end
          OP_BRANCH: begin
            // Taken target already sits in ALUOut from ID; ALU is free to compare.
            alu_src_a_d = 1'b1;
            alu_src_b_d = SRCB_B;
            alu_op_d    = ALUOP_BRANCH;
            pc_write_d  = 1'b1;
            pc_source_d = bcond ? PCSRC_ALUOUT : PCSRC_PC4;
            state_d     = S_IF;
          end
          OP_JAL: begin
            // Link PC+4 and jump to PC+imm held in ALUOut.
            reg_write_d = 1'b1;
            pc_to_reg_d = 1'b1;
            pc_write_d  = 1'b1;
            pc_source_d = PCSRC_ALUOUT;
            state_d     = S_IF;
          end
          OP_JALR: begin
            // Target A+imm is computed this cycle, so PC takes the live ALU result.
            alu_src_a_d = 1'b1;
            alu_src_b_d = SRCB_IMM;
            alu_op_d    = ALUOP_ADD;
            reg_write_d = 1'b1;
            pc_to_reg_d = 1'b1;
            pc_write_d  = 1'b1;
            pc_source_d = PCSRC_ALU;
            state_d     = S_IF;
          end
          default: begin
            // Unrecognised opcode retires as a NOP.
            pc_write_d  = 1'b1;
            pc_source_d = PCSRC_PC4;
            state_d     = S_IF;
          end
        endcase
      end

      S_MEM: begin
        // Address from ALUOut; strobes held steady across the wait.
        i_or_d_d    = 1'b1;
        mem_read_d  = (opcode == OP_LOAD);
        mem_write_d = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write_d  = 1'b1;
            pc_source_d = PCSRC_PC4;
            state_d     = S_IF;
          end
        end
      end

      S_WB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = (opcode == OP_LOAD);
        pc_write_d   = 1'b1;
        pc_source_d  = PCSRC_PC4;
        state_d      = S_IF;
      end

      S_ECALL: begin
        if (halt_req) begin
          // PC is left pointing at the ecall.
          state_d = S_HALT;
        end else begin
          pc_write_d  = 1'b1;
          pc_source_d = PCSRC_PC4;
          state_d     = S_IF;
        end
      end

      S_HALT: begin
        is_halted_d = 1'b1;
        state_d     = S_HALT;
      end

      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Only EX/MEM/WB/ECALL -> IF retires; entering HALT does not.
  assign retire_en = (state_d == S_IF) && is_retire_state(state_q);

  // ---------------------------------------------------------------------------
  // Output stage: reset overrides the decode combinationally so that strobes
  // drop the moment reset rises, not at the next clock edge. The reset state
  // (IF) would otherwise present mem_read.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = PCSRC_ALU;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALUOP_ADD;
    is_halted  = 1'b0;
    if (!reset) begin
      pc_write   = pc_write_d;
      pc_source  = pc_source_d;
      i_or_d     = i_or_d_d;
      mem_read   = mem_read_d;
      mem_write  = mem_write_d;
      ir_write   = ir_write_d;
      reg_write  = reg_write_d;
      mem_to_reg = mem_to_reg_d;
      pc_to_reg  = pc_to_reg_d;
      alu_src_a  = alu_src_a_d;
      alu_src_b  = alu_src_b_d;
      alu_op     = alu_op_d;
      is_halted  = is_halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------------
  instret_counter #(
    .CNT_W (CNT_W)
  ) u_instret_counter (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (retire_en),
    .count_o (instret)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//   Randomized self-checking bench. For each instruction the bench expands the
//   opcode class into its expected per-cycle control trace (IF waits, fetch,
//   decode, class-specific phases, memory waits) and compares the DUT every
//   cycle, plus the retired-instruction count after each instruction.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] SYS_OP = 7'b1110011;

  typedef struct packed {
    logic       halted;
    logic       pcw;
    logic [1:0] pcs;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       m2r;
    logic       p2r;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        bcond;
  logic        mem_ready;
  logic        halt_req;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_to_reg;
  logic        pc_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        is_halted;
  logic [31:0] instret;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_instret = 0;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .bcond      (bcond),
    .mem_ready  (mem_ready),
    .halt_req   (halt_req),
    .pc_write   (pc_write),
    .pc_source  (pc_source),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .pc_to_reg  (pc_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .is_halted  (is_halted),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t dut_ctl();
    ctl_t d;
    d = {is_halted, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
         reg_write, mem_to_reg, pc_to_reg, alu_src_a, alu_src_b, alu_op};
    return d;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic is_known(input logic [6:0] o);
    return (o == R_OP) || (o == I_OP) || (o == LD_OP) || (o == ST_OP) ||
           (o == BR_OP) || (o == JAL_OP) || (o == JR_OP) || (o == SYS_OP);
  endfunction

  function automatic logic [6:0] rand_unknown();
    logic [6:0] o;
    o = 7'($urandom);
    while (is_known(o)) o = 7'($urandom);
    return o;
  endfunction

  // One clock: entered at posedge+1, drives inputs, checks at negedge,
  // returns at the following posedge+1.
  task automatic cyc(input logic [6:0] op, input logic mr, input logic bc,
                     input logic hr, input ctl_t e, input string tag);
    opcode    = op;
    mem_ready = mr;
    bcond     = bc;
    halt_req  = hr;
    @(negedge clk);
    check_val(tag, 32'(dut_ctl()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its expected control trace and apply it.
  task automatic run_instr(input logic [6:0] op, input int ifw, input int memw,
                           input logic bc, input logic hr);
    ctl_t e;
    int   cycles = 0;
    for (int i = 0; i < ifw; i++) begin
      e = '0; e.mr = 1'b1;
      cyc(7'($urandom), 1'b0, rb(), rb(), e, "if_wait"); cycles++;
    end
    e = '0; e.mr = 1'b1; e.irw = 1'b1;
    cyc(7'($urandom), 1'b1, rb(), rb(), e, "if_fetch"); cycles++;
    e = '0; e.asb = 2'b10;
    cyc(op, rb(), rb(), rb(), e, "id"); cycles++;

    if (op == SYS_OP) begin
      e = '0;
      if (!hr) begin e.pcw = 1'b1; e.pcs = 2'b10; end
      cyc(op, rb(), rb(), hr, e, "ecall"); cycles++;
      if (!hr) exp_instret++;
    end else begin
      e = '0;
      case (op)
        R_OP:   begin e.asa = 1'b1; e.aop = 2'b10; end
        I_OP:   begin e.asa = 1'b1; e.asb = 2'b10; e.aop = 2'b10; end
        LD_OP, ST_OP: begin e.asa = 1'b1; e.asb = 2'b10; end
        BR_OP:  begin e.asa = 1'b1; e.aop = 2'b01; e.pcw = 1'b1; e.pcs = bc ? 2'b01 : 2'b10; end
        JAL_OP: begin e.rw = 1'b1; e.p2r = 1'b1; e.pcw = 1'b1; e.pcs = 2'b01; end
        JR_OP:  begin e.asa = 1'b1; e.asb = 2'b10; e.rw = 1'b1; e.p2r = 1'b1; e.pcw = 1'b1; e.pcs = 2'b00; end
        default: begin e.pcw = 1'b1; e.pcs = 2'b10; end
      endcase
      cyc(op, rb(), (op == BR_OP) ? bc : rb(), rb(), e, "ex"); cycles++;

      if (op == LD_OP || op == ST_OP) begin
        for (int i = 0; i < memw; i++) begin
          e = '0; e.iod = 1'b1; e.mr = (op == LD_OP); e.mw = (op == ST_OP);
          cyc(op, 1'b0, rb(), rb(), e, "mem_wait"); cycles++;
        end
        e = '0; e.iod = 1'b1; e.mr = (op == LD_OP); e.mw = (op == ST_OP);
        if (op == ST_OP) begin e.pcw = 1'b1; e.pcs = 2'b10; end
        cyc(op, 1'b1, rb(), rb(), e, "mem_done"); cycles++;
      end

      if (op == R_OP || op == I_OP || op == LD_OP) begin
        e = '0; e.rw = 1'b1; e.m2r = (op == LD_OP); e.pcw = 1'b1; e.pcs = 2'b10;
        cyc(op, rb(), rb(), rb(), e, "wb"); cycles++;
      end
      exp_instret++;
    end
    check_val("instret", instret, exp_instret);
    $display("instr op=%b ifw=%0d memw=%0d bcond=%0b halt=%0b cycles=%0d instret=%0d",
             op, ifw, memw, bc, hr, cycles, instret);
  endtask

  initial begin
    ctl_t        e;
    logic [6:0]  ops [8];
    int          k;
    ops = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JR_OP, SYS_OP};

    reset = 1'b1; opcode = '0; bcond = 1'b0; mem_ready = 1'b1; halt_req = 1'b0;
    @(posedge clk); #1;
    check_val("rst_ctl", 32'(dut_ctl()), 32'(0));
    check_val("rst_instret", instret, 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases
    run_instr(R_OP,   0, 0, 1'b0, 1'b0);
    run_instr(LD_OP,  2, 3, 1'b0, 1'b0);
    run_instr(BR_OP,  0, 0, 1'b1, 1'b0);
    run_instr(BR_OP,  0, 0, 1'b0, 1'b0);
    run_instr(JR_OP,  0, 0, 1'b0, 1'b0);
    run_instr(SYS_OP, 0, 0, 1'b0, 1'b0);
    run_instr(rand_unknown(), 1, 0, 1'b0, 1'b0);

    // Random instruction stream
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 8);
      run_instr((k == 8) ? rand_unknown() : ops[k],
                $urandom_range(0, 3), $urandom_range(0, 3), rb(), 1'b0);
    end

    // ecall with halt request parks the core
    run_instr(SYS_OP, $urandom_range(0, 2), 0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      e = '0; e.halted = 1'b1;
      cyc(7'($urandom), logic'(i % 2), rb(), rb(), e, "halt");
    end
    check_val("halt_instret", instret, exp_instret);

    // Reset out of HALT
    reset = 1'b1; #1;
    exp_instret = 0;
    check_val("halt_rst_ctl", 32'(dut_ctl()), 32'(0));
    check_val("halt_rst_instret", instret, exp_instret);
    @(posedge clk); #1;
    reset = 1'b0;

    // Asynchronous reset mid-MEM of a store
    run_instr(I_OP, 0, 0, 1'b0, 1'b0);
    e = '0; e.mr = 1'b1; e.irw = 1'b1;
    cyc(7'($urandom), 1'b1, 1'b0, 1'b0, e, "st_fetch");
    e = '0; e.asb = 2'b10;
    cyc(ST_OP, 1'b1, 1'b0, 1'b0, e, "st_id");
    e = '0; e.asa = 1'b1; e.asb = 2'b10;
    cyc(ST_OP, 1'b1, 1'b0, 1'b0, e, "st_ex");
    opcode = ST_OP; mem_ready = 1'b0;
    #2;
    e = '0; e.iod = 1'b1; e.mw = 1'b1;
    check_val("st_mem_hold", 32'(dut_ctl()), 32'(e));
    reset = 1'b1;
    #1;
    exp_instret = 0;
    check_val("st_async_rst_ctl", 32'(dut_ctl()), 32'(0));
    check_val("st_async_rst_instret", instret, exp_instret);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("instr op=%b reset mid-MEM instret=%0d", ST_OP, instret);
    run_instr(R_OP, 0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
